// File: rtl/vx_fp_bf16_pkg.sv
// Shared types and constants for the BF16 divide sequencer.
package vx_fp_bf16_pkg;

  localparam int INST_FRM_BITS = 3;

  localparam int          BF16_EXP_BIAS = 127;
  localparam logic [15:0] BF16_QNAN     = 16'h7FC0;
  localparam logic [14:0] BF16_MAXF     = 15'h7F7F;

  // Rounding-mode encodings carried on frm
  localparam logic [INST_FRM_BITS-1:0] FRM_RNE = 3'd0;
  localparam logic [INST_FRM_BITS-1:0] FRM_RTZ = 3'd1;
  localparam logic [INST_FRM_BITS-1:0] FRM_RDN = 3'd2;
  localparam logic [INST_FRM_BITS-1:0] FRM_RUP = 3'd3;
  localparam logic [INST_FRM_BITS-1:0] FRM_RMM = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ITER  = 3'd2,
    ST_ROUND = 3'd3,
    ST_PACK  = 3'd4,
    ST_DONE  = 3'd5
  } div_state_e;

  // Bit order matches the RISC-V fflags CSR: {NV, DZ, OF, UF, NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

endpackage

// File: rtl/vx_fp_bf16_div_iter.sv
// Single-lane restoring mantissa divider: one quotient bit per step, 9 steps.
module vx_fp_bf16_div_iter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [8:0] ma,
  input  logic [7:0] mb,
  output logic [9:0] q,
  output logic       sticky,
  output logic       done
);

  logic [8:0] rem_q;
  logic [9:0] q_q;
  logic [7:0] mb_q;
  logic [3:0] cnt_q;
  logic [8:0] rem_sh;
  logic       ge;

  // The remainder is always below mb (< 256), so the shifted value fits 9 bits
  assign rem_sh = {rem_q[7:0], 1'b0};
  assign ge     = (rem_sh >= {1'b0, mb_q});

  // Load seeds rem = ma - mb with q = 1; each step is a compare-subtract-shift
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q <= '0;
      q_q   <= '0;
      mb_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= ma - {1'b0, mb};
      q_q   <= 10'd1;
      mb_q  <= mb;
      cnt_q <= 4'd8;
    end else if (step) begin
      rem_q <= ge ? (rem_sh - {1'b0, mb_q}) : rem_sh;
      q_q   <= {q_q[8:0], ge};
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end
  end

  assign q      = q_q;
  assign sticky = (rem_q != 9'd0);
  // High while the final step is being taken
  assign done   = (cnt_q == 4'd0);

endmodule

// File: rtl/vx_fp_bf16_div_ctrl.sv
// Warp-wide BF16 divide sequencer sharing one iterative divider across lanes.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid_out holds with result/fflags/tag_out stable until taken.
module vx_fp_bf16_div_ctrl
  import vx_fp_bf16_pkg::*;
#(
  parameter int TAGW  = 1,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [TAGW-1:0]          tag_in,
  input  logic [INST_FRM_BITS-1:0] frm,
  input  logic [LANES*32-1:0]      dataa,
  input  logic [LANES*32-1:0]      datab,
  output logic [LANES*32-1:0]      result,
  output logic                     has_fflags,
  output fflags_t [LANES-1:0]      fflags,
  output logic [TAGW-1:0]          tag_out,
  output logic                     valid_out,
  input  logic                     ready_out,
  output div_state_e               dbg_state
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

  div_state_e               state_q;
  logic [LIDX_W-1:0]        lane_q;
  logic [LANES*16-1:0]      a_q, b_q;
  logic [INST_FRM_BITS-1:0] frm_q;
  logic                     sign_q;
  logic [9:0]               exp_q;
  logic [15:0]              res_lane_q;
  fflags_t                  flg_lane_q;

  logic [LANES*16-1:0] a_hi, b_hi;
  logic                unused_low;
  logic [15:0]         a_h, b_h;

  assign has_fflags = 1'b1;
  assign dbg_state  = state_q;

  // Keep only the BF16 halves of the incoming operands
  always_comb begin
    a_hi       = '0;
    b_hi       = '0;
    unused_low = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a_hi[i*16 +: 16] = dataa[i*32+16 +: 16];
      b_hi[i*16 +: 16] = datab[i*32+16 +: 16];
      unused_low = unused_low ^ (^dataa[i*32 +: 16]) ^ (^datab[i*32 +: 16]);
    end
  end

  // Select the operands of the lane currently being processed
  always_comb begin
    a_h = '0;
    b_h = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LIDX_W'(i)) begin
        a_h = a_q[i*16 +: 16];
        b_h = b_q[i*16 +: 16];
      end
    end
  end

  logic       sa, sb, sign_r;
  logic [7:0] ea, eb;
  logic [6:0] fa, fb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign sa = a_h[15];
  assign sb = b_h[15];
  assign ea = a_h[14:7];
  assign eb = b_h[14:7];
  assign fa = a_h[6:0];
  assign fb = b_h[6:0];
  // Exponent 0 covers both zero and subnormal, so subnormals flush to zero
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (fa == 7'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 7'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 7'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 7'd0);
  assign sign_r = sa ^ sb;

  logic        is_special;
  logic [15:0] sp_res;
  fflags_t     sp_flg;

  // Special-operand resolution in priority order
  always_comb begin
    is_special = 1'b1;
    sp_res     = '0;
    sp_flg     = '0;
    if (a_nan || b_nan) begin
      sp_res    = BF16_QNAN;
      sp_flg.nv = (a_nan && !fa[6]) || (b_nan && !fb[6]);
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      sp_res    = BF16_QNAN;
      sp_flg.nv = 1'b1;
    end else if (b_zero) begin
      sp_res    = {sign_r, 8'hFF, 7'h00};
      sp_flg.dz = 1'b1;
    end else if (a_inf) begin
      sp_res = {sign_r, 8'hFF, 7'h00};
    end else if (a_zero || b_inf) begin
      sp_res = {sign_r, 15'h0000};
    end else begin
      is_special = 1'b0;
    end
  end

  logic [7:0] ma, mb;
  logic       m_lt;
  logic [8:0] ma_n;
  logic [9:0] e_calc;

  // Pre-normalise so the quotient always lands in [1, 2)
  assign ma     = {1'b1, fa};
  assign mb     = {1'b1, fb};
  assign m_lt   = (ma < mb);
  assign ma_n   = m_lt ? {ma, 1'b0} : {1'b0, ma};
  assign e_calc = {2'b00, ea} - {2'b00, eb} + 10'(BF16_EXP_BIAS) - {9'd0, m_lt};

  logic [9:0] iq;
  logic       isticky, idone, iload, istep;
  logic       unused_q9;

  assign iload     = (state_q == ST_SETUP) && !is_special;
  assign istep     = (state_q == ST_ITER);
  assign unused_q9 = iq[9];

  vx_fp_bf16_div_iter u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (iload),
    .step   (istep),
    .ma     (ma_n),
    .mb     (mb),
    .q      (iq),
    .sticky (isticky),
    .done   (idone)
  );

  logic        inexact, inc, to_inf;
  logic [7:0]  mant_sum;
  logic [9:0]  e_rnd;
  logic [15:0] rnd_res;
  fflags_t     rnd_flg;

  // Round the 10-bit quotient and detect overflow/underflow on the final exponent
  always_comb begin
    rnd_res  = '0;
    rnd_flg  = '0;
    inexact  = iq[1] | iq[0] | isticky;
    inc      = 1'b0;
    to_inf   = 1'b1;
    case (frm_q)
      FRM_RTZ: begin inc = 1'b0;               to_inf = 1'b0;    end
      FRM_RDN: begin inc = inexact & sign_q;   to_inf = sign_q;  end
      FRM_RUP: begin inc = inexact & ~sign_q;  to_inf = ~sign_q; end
      FRM_RMM: begin inc = iq[1];              to_inf = 1'b1;    end
      default: begin inc = iq[1] & (iq[0] | isticky | iq[2]); to_inf = 1'b1; end
    endcase
    mant_sum = {1'b0, iq[8:2]} + {7'd0, inc};
    e_rnd    = exp_q + {9'd0, mant_sum[7]};
    if ($signed(e_rnd) >= 10'sd255) begin
      rnd_flg.of = 1'b1;
      rnd_flg.nx = 1'b1;
      rnd_res    = to_inf ? {sign_q, 8'hFF, 7'h00} : {sign_q, BF16_MAXF};
    end else if ($signed(e_rnd) <= 10'sd0) begin
      rnd_flg.uf = 1'b1;
      rnd_flg.nx = 1'b1;
      rnd_res    = {sign_q, 15'h0000};
    end else begin
      rnd_flg.nx = inexact;
      rnd_res    = {sign_q, e_rnd[7:0], mant_sum[6:0]};
    end
  end

  // Sequencer FSM with registered handshake outputs and per-lane result demux
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ready_in   <= 1'b1;
      valid_out  <= 1'b0;
      result     <= '0;
      fflags     <= '0;
      tag_out    <= '0;
      lane_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      frm_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      res_lane_q <= '0;
      flg_lane_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_in && ready_in) begin
            a_q      <= a_hi;
            b_q      <= b_hi;
            frm_q    <= frm;
            tag_out  <= tag_in;
            result   <= '0;
            fflags   <= '0;
            lane_q   <= '0;
            ready_in <= 1'b0;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          sign_q <= sign_r;
          exp_q  <= e_calc;
          if (is_special) begin
            res_lane_q <= sp_res;
            flg_lane_q <= sp_flg;
            state_q    <= ST_PACK;
          end else begin
            state_q <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (idone) state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          res_lane_q <= rnd_res;
          flg_lane_q <= rnd_flg;
          state_q    <= ST_PACK;
        end
        ST_PACK: begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_q == LIDX_W'(i)) begin
              result[i*32+16 +: 16] <= res_lane_q;
              fflags[i]             <= flg_lane_q;
            end
          end
          if (lane_q == LAST_LANE) begin
            valid_out <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            lane_q  <= lane_q + LIDX_W'(1);
            state_q <= ST_SETUP;
          end
        end
        ST_DONE: begin
          if (ready_out) begin
            valid_out <= 1'b0;
            ready_in  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_in  <= 1'b1;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vx_fp_bf16_div_ctrl.sv
// Directed bench for the BF16 divide sequencer (4-lane and 1-lane instances).
module tb_vx_fp_bf16_div_ctrl;
  import vx_fp_bf16_pkg::*;

  localparam logic [4:0] F_NV = 5'h10;
  localparam logic [4:0] F_DZ = 5'h08;
  localparam logic [4:0] F_OF = 5'h04;
  localparam logic [4:0] F_UF = 5'h02;
  localparam logic [4:0] F_NX = 5'h01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-lane DUT ----------------
  logic           valid_in = 1'b0;
  logic           ready_in;
  logic [3:0]     tag_in = '0;
  logic [2:0]     frm = '0;
  logic [127:0]   dataa = '0;
  logic [127:0]   datab = '0;
  logic [127:0]   result;
  logic           has_fflags;
  fflags_t [3:0]  fflags;
  logic [3:0]     tag_out;
  logic           valid_out;
  logic           ready_out = 1'b0;
  div_state_e     dbg_state;

  vx_fp_bf16_div_ctrl #(.TAGW(4), .LANES(4)) u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .tag_in(tag_in), .frm(frm), .dataa(dataa), .datab(datab),
    .result(result), .has_fflags(has_fflags), .fflags(fflags),
    .tag_out(tag_out), .valid_out(valid_out), .ready_out(ready_out),
    .dbg_state(dbg_state)
  );

  // ---------------- 1-lane DUT ----------------
  logic          s_valid_in = 1'b0;
  logic          s_ready_in;
  logic [0:0]    s_tag_in = '0;
  logic [2:0]    s_frm = '0;
  logic [31:0]   s_dataa = '0;
  logic [31:0]   s_datab = '0;
  logic [31:0]   s_result;
  logic          s_has_fflags;
  fflags_t [0:0] s_fflags;
  logic [0:0]    s_tag_out;
  logic          s_valid_out;
  logic          s_ready_out = 1'b0;
  div_state_e    s_dbg_state;

  vx_fp_bf16_div_ctrl #(.TAGW(1), .LANES(1)) u_dut1 (
    .clk(clk), .reset(reset), .valid_in(s_valid_in), .ready_in(s_ready_in),
    .tag_in(s_tag_in), .frm(s_frm), .dataa(s_dataa), .datab(s_datab),
    .result(s_result), .has_fflags(s_has_fflags), .fflags(s_fflags),
    .tag_out(s_tag_out), .valid_out(s_valid_out), .ready_out(s_ready_out),
    .dbg_state(s_dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Low halves carry junk that the DUT must ignore
  function automatic logic [127:0] pack4(input logic [15:0] h0, h1, h2, h3);
    return {h3, 16'h5A5A, h2, 16'hA5A5, h1, 16'h1234, h0, 16'hFFFF};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] a, input logic [127:0] b,
                      input logic [2:0] f, input logic [3:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (ready_in !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: ready_in=%b required 1", ready_in);
    end
    valid_in = 1'b1; dataa = a; datab = b; frm = f; tag_in = t;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    ready_out = 1'b1;
    @(posedge clk);
    #1 ready_out = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out: got %b required 0", valid_out); end
    tests_run++;
    if (ready_in !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_in: got %b required 1", ready_in); end
    tests_run++;
    if (result !== 128'd0) begin tests_failed++; $display("FAIL reset_result: got %h required 0", result); end
    tests_run++;
    if (fflags !== 20'd0) begin tests_failed++; $display("FAIL reset_fflags: got %h required 0", fflags); end
    tests_run++;
    if (tag_out !== 4'd0) begin tests_failed++; $display("FAIL reset_tag: got %h required 0", tag_out); end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
    tests_run++;
    if (has_fflags !== 1'b1) begin tests_failed++; $display("FAIL has_fflags: got %b required 1", has_fflags); end
  endtask

  task automatic test_single_lane();
    int lat;
    @(negedge clk);
    s_valid_in = 1'b1; s_dataa = {16'h3FC0, 16'hBEEF}; s_datab = {16'h3F80, 16'h0F0F};
    s_frm = FRM_RNE; s_tag_in = 1'b1;
    @(posedge clk);
    #1 s_valid_in = 1'b0;
    lat = 0;
    while (s_valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests_run++;
    if (lat != 12) begin tests_failed++; $display("FAIL single_latency: got %0d required 12", lat); end
    tests_run++;
    if (s_result !== 32'h3FC0_0000) begin tests_failed++; $display("FAIL single_result: got %h required 3fc00000", s_result); end
    tests_run++;
    if (s_fflags !== 5'd0) begin tests_failed++; $display("FAIL single_fflags: got %h required 0", s_fflags); end
    tests_run++;
    if (s_tag_out !== 1'b1) begin tests_failed++; $display("FAIL single_tag: got %b required 1", s_tag_out); end
    @(negedge clk);
    s_ready_out = 1'b1;
    @(posedge clk);
    #1 s_ready_out = 1'b0;
    tests_run++;
    if (s_valid_out !== 1'b0 || s_ready_in !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_handshake: valid_out=%b ready_in=%b required 0/1", s_valid_out, s_ready_in);
    end
  endtask

  // Same four normal-path lanes under RNE then RTZ
  task automatic test_rounding(input logic [2:0] f, input logic [3:0] t);
    int lat;
    logic [15:0] er[4];
    logic [4:0]  ef[4];
    if (f == FRM_RTZ) begin
      er = '{16'h3EAA, 16'h3FC0, 16'h7F7F, 16'h0000};
    end else begin
      er = '{16'h3EAB, 16'h3FC0, 16'h7F80, 16'h0000};
    end
    ef = '{F_NX, 5'd0, F_OF | F_NX, F_UF | F_NX};
    send(pack4(16'h3F80, 16'h3FC0, 16'h7F00, 16'h0080),
         pack4(16'h4040, 16'h3F80, 16'h0080, 16'h4000), f, t);
    wait_valid(lat);
    tests_run++;
    if (lat != 48) begin tests_failed++; $display("FAIL round%0d_latency: got %0d required 48", f, lat); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (result[i*32 +: 32] !== {er[i], 16'h0000}) begin
        tests_failed++;
        $display("FAIL round%0d_result lane%0d: got %h required %h", f, i, result[i*32 +: 32], {er[i], 16'h0000});
      end
      tests_run++;
      if (fflags[i] !== ef[i]) begin
        tests_failed++;
        $display("FAIL round%0d_fflags lane%0d: got %h required %h", f, i, fflags[i], ef[i]);
      end
    end
    tests_run++;
    if (tag_out !== t) begin tests_failed++; $display("FAIL round%0d_tag: got %h required %h", f, tag_out, t); end
    pop();
  endtask

  task automatic test_directed_rdn();
    int lat;
    logic [15:0] er[4];
    logic [4:0]  ef[4];
    er = '{16'hBEAB, 16'h3EAA, 16'h7F7F, 16'hFF80};
    ef = '{F_NX, F_NX, F_OF | F_NX, F_OF | F_NX};
    send(pack4(16'hBF80, 16'h3F80, 16'h7F00, 16'hFF00),
         pack4(16'h4040, 16'h4040, 16'h0080, 16'h0080), FRM_RDN, 4'h7);
    wait_valid(lat);
    tests_run++;
    if (lat != 48) begin tests_failed++; $display("FAIL rdn_latency: got %0d required 48", lat); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (result[i*32 +: 32] !== {er[i], 16'h0000}) begin
        tests_failed++;
        $display("FAIL rdn_result lane%0d: got %h required %h", i, result[i*32 +: 32], {er[i], 16'h0000});
      end
      tests_run++;
      if (fflags[i] !== ef[i]) begin
        tests_failed++;
        $display("FAIL rdn_fflags lane%0d: got %h required %h", i, fflags[i], ef[i]);
      end
    end
    pop();
  endtask

  task automatic test_specials();
    int lat;
    logic [15:0] er[4];
    logic [4:0]  ef[4];
    er = '{16'h7F80, 16'h7FC0, 16'h7FC0, 16'h7F80};
    ef = '{F_DZ, F_NV, F_NV, 5'd0};
    send(pack4(16'h3F80, 16'h0000, 16'h7F81, 16'h7F80),
         pack4(16'h0000, 16'h0000, 16'h3F80, 16'h4000), FRM_RNE, 4'h3);
    wait_valid(lat);
    tests_run++;
    if (lat != 8) begin tests_failed++; $display("FAIL special_latency: got %0d required 8", lat); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (result[i*32 +: 32] !== {er[i], 16'h0000}) begin
        tests_failed++;
        $display("FAIL special_result lane%0d: got %h required %h", i, result[i*32 +: 32], {er[i], 16'h0000});
      end
      tests_run++;
      if (fflags[i] !== ef[i]) begin
        tests_failed++;
        $display("FAIL special_fflags lane%0d: got %h required %h", i, fflags[i], ef[i]);
      end
    end
    pop();
    tests_run++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
      tests_failed++;
      $display("FAIL special_handshake: valid_out=%b ready_in=%b required 0/1", valid_out, ready_in);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] exp_res;
    logic [19:0]  exp_flg;
    exp_res = {16'h7F80, 16'h0, 16'h7FC0, 16'h0, 16'h7FC0, 16'h0, 16'h7F80, 16'h0};
    exp_flg = {5'd0, F_NV, F_NV, F_DZ};
    send(pack4(16'h3F80, 16'h0000, 16'h7F81, 16'h7F80),
         pack4(16'h0000, 16'h0000, 16'h3F80, 16'h4000), FRM_RNE, 4'h5);
    wait_valid(lat);
    tests_run++;
    if (lat != 8) begin tests_failed++; $display("FAIL bp_latency: got %0d required 8", lat); end
    // Offer a new request while the response is stalled; it must not be taken
    @(negedge clk);
    valid_in = 1'b1;
    dataa = pack4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80);
    datab = dataa;
    tag_in = 4'hE;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (valid_out !== 1'b1 || ready_in !== 1'b0 || result !== exp_res ||
          fflags !== exp_flg || tag_out !== 4'h5) begin
        tests_failed++;
        $display("FAIL bp_hold cycle%0d: valid_out=%b ready_in=%b result=%h fflags=%h tag=%h required 1/0/%h/%h/5",
                 c, valid_out, ready_in, result, fflags, tag_out, exp_res, exp_flg);
      end
    end
    valid_in = 1'b0;
    pop();
    tests_run++;
    if (dbg_state !== ST_IDLE || ready_in !== 1'b1 || valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: state=%0d ready_in=%b valid_out=%b required IDLE/1/0", dbg_state, ready_in, valid_out);
    end
    // Back-to-back: the next request is accepted and completes normally
    send(pack4(16'h3FC0, 16'h3FC0, 16'h3FC0, 16'h3FC0),
         pack4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80), FRM_RNE, 4'h6);
    wait_valid(lat);
    tests_run++;
    if (lat != 48) begin tests_failed++; $display("FAIL b2b_latency: got %0d required 48", lat); end
    tests_run++;
    if (result !== {4{16'h3FC0, 16'h0000}} || fflags !== 20'd0 || tag_out !== 4'h6) begin
      tests_failed++;
      $display("FAIL b2b_value: result=%h fflags=%h tag=%h required %h/0/6", result, fflags, tag_out, {4{16'h3FC0, 16'h0000}});
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [15:0] er[4];
    logic [4:0]  ef[4];
    send(pack4(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80),
         pack4(16'h4040, 16'h4040, 16'h4040, 16'h4040), FRM_RNE, 4'h9);
    repeat (28) @(posedge clk);
    #1;
    tests_run++;
    if (dbg_state !== ST_ITER) begin tests_failed++; $display("FAIL mid_state: got %0d required %0d", dbg_state, ST_ITER); end
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    tests_run++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL mid_reset: valid_out=%b ready_in=%b state=%0d required 0/1/IDLE", valid_out, ready_in, dbg_state);
    end
    tests_run++;
    if (result !== 128'd0 || fflags !== 20'd0 || tag_out !== 4'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_regs: result=%h fflags=%h tag=%h required 0", result, fflags, tag_out);
    end
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (valid_out === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL mid_no_response: valid_out high %0d cycles required 0", seen); end
    er = '{16'h3EAB, 16'h3FC0, 16'hBEAB, 16'h4000};
    ef = '{F_NX, 5'd0, F_NX, 5'd0};
    send(pack4(16'h3F80, 16'h3FC0, 16'hBF80, 16'h4000),
         pack4(16'h4040, 16'h3F80, 16'h4040, 16'h3F80), FRM_RNE, 4'hA);
    wait_valid(lat);
    tests_run++;
    if (lat != 48) begin tests_failed++; $display("FAIL post_reset_latency: got %0d required 48", lat); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (result[i*32 +: 32] !== {er[i], 16'h0000} || fflags[i] !== ef[i]) begin
        tests_failed++;
        $display("FAIL post_reset lane%0d: result=%h fflags=%h required %h/%h",
                 i, result[i*32 +: 32], fflags[i], {er[i], 16'h0000}, ef[i]);
      end
    end
    tests_run++;
    if (tag_out !== 4'hA) begin tests_failed++; $display("FAIL post_reset_tag: got %h required a", tag_out); end
    pop();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_lane();
    test_rounding(FRM_RNE, 4'h1);
    test_rounding(FRM_RTZ, 4'h2);
    test_directed_rdn();
    test_specials();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
